// File: rtl/sobel_window_gen.sv
// Raster pixel stream to 3x3 window generator for the Sobel chain.
// Optional border zero-padding with end-of-frame flush: SOBEL_WINDOW_ZERO_PAD_EN.
module sobel_window_gen #(
    parameter int NBIT        = 8,
    parameter int KERNEL_SIZE = 3,
    parameter int IMG_WIDTH   = 640,
    parameter int IMG_HEIGHT  = 480
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic [NBIT-1:0] i_pixel,
    input  logic            i_pixel_valid,
    output logic            o_ready,
    output logic [NBIT-1:0] o_window [KERNEL_SIZE][KERNEL_SIZE],
    output logic            o_window_valid,
    output logic            o_frame_done
);

    localparam int K  = KERNEL_SIZE;
    localparam int CW = $clog2(IMG_WIDTH);
    localparam int RW = $clog2(IMG_HEIGHT);

    localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);
    localparam logic [CW-1:0] COL_TWO  = CW'(2);
    localparam logic [RW-1:0] ROW_TWO  = RW'(2);

    typedef enum logic {
        STREAM = 1'b0,
        FLUSH  = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   col_q, col_d;
    logic [RW-1:0]   row_q, row_d;
    logic [NBIT-1:0] lb0_q [IMG_WIDTH];
    logic [NBIT-1:0] lb1_q [IMG_WIDTH];
    logic [NBIT-1:0] win_q [K][K];
    logic [NBIT-1:0] win_d [K][K];
    logic [NBIT-1:0] out_q [K][K];
    logic [NBIT-1:0] out_d [K][K];
    logic [NBIT-1:0] col_new [K];
    logic            valid_q, valid_d;
    logic            done_q, done_d;
    logic            xfer;
    logic            adv;
    logic            emit;
    logic            last_px;
    logic [CW-1:0]   addr;
    logic [NBIT-1:0] pix;

`ifdef SOBEL_WINDOW_ZERO_PAD_EN
    localparam int FW = $clog2(IMG_WIDTH + 1);
    localparam logic [FW-1:0] FCNT_LAST = FW'(IMG_WIDTH);

    logic [FW-1:0] fcnt_q, fcnt_d;
    logic [RW-1:0] cr_q, cr_d;
    logic [CW-1:0] cc_q, cc_d;
    logic          flushing;

    assign flushing = (state_q == FLUSH);
    assign o_ready  = (state_q == STREAM);
`else
    assign o_ready  = 1'b1;
`endif

    assign xfer           = i_pixel_valid && o_ready;
    assign last_px        = (row_q == ROW_LAST) && (col_q == COL_LAST);
    assign o_window       = out_q;
    assign o_window_valid = valid_q;
    assign o_frame_done   = done_q;

    // Next-state: counters, FSM, window shift and emitted window.
    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        row_d   = row_q;
        win_d   = win_q;
        out_d   = out_q;
        valid_d = 1'b0;
        done_d  = 1'b0;
`ifdef SOBEL_WINDOW_ZERO_PAD_EN
        fcnt_d  = fcnt_q;
        cr_d    = cr_q;
        cc_d    = cc_q;
        adv     = xfer || flushing;
        pix     = flushing ? '0 : i_pixel;
        if (flushing) begin
            addr = (fcnt_q == FCNT_LAST) ? '0 : fcnt_q[CW-1:0];
        end else begin
            addr = col_q;
        end
        emit = flushing ||
               (xfer && ((row_q >= ROW_TWO) ||
                         ((row_q == RW'(1)) && (col_q != '0))));
`else
        adv  = xfer;
        pix  = i_pixel;
        addr = col_q;
        emit = xfer && (row_q >= ROW_TWO) && (col_q >= COL_TWO);
`endif

        col_new[0] = lb0_q[addr];
        col_new[1] = lb1_q[addr];
        col_new[2] = pix;

        if (adv) begin
            for (int i = 0; i < K; i++) begin
                for (int j = 0; j < K - 1; j++) begin
                    win_d[i][j] = win_q[i][j+1];
                end
                win_d[i][K-1] = col_new[i];
            end
        end

        if (xfer) begin
            if (col_q == COL_LAST) begin
                col_d = '0;
                row_d = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
        end

        case (state_q)
            STREAM: begin
`ifdef SOBEL_WINDOW_ZERO_PAD_EN
                if (xfer && last_px) begin
                    state_d = FLUSH;
                    fcnt_d  = '0;
                end
`endif
            end
            FLUSH: begin
`ifdef SOBEL_WINDOW_ZERO_PAD_EN
                fcnt_d = fcnt_q + 1'b1;
                if (fcnt_q == FCNT_LAST) begin
                    state_d = STREAM;
                end
`else
                state_d = STREAM;
`endif
            end
            default: state_d = STREAM;
        endcase

        if (emit) begin
            valid_d = 1'b1;
            out_d   = win_d;
`ifdef SOBEL_WINDOW_ZERO_PAD_EN
            for (int i = 0; i < K; i++) begin
                for (int j = 0; j < K; j++) begin
                    if ((i == 0 && cr_q == '0) ||
                        (i == K - 1 && cr_q == ROW_LAST) ||
                        (j == 0 && cc_q == '0) ||
                        (j == K - 1 && cc_q == COL_LAST)) begin
                        out_d[i][j] = '0;
                    end
                end
            end
            done_d = (cr_q == ROW_LAST) && (cc_q == COL_LAST);
            if (cc_q == COL_LAST) begin
                cc_d = '0;
                cr_d = (cr_q == ROW_LAST) ? '0 : cr_q + 1'b1;
            end else begin
                cc_d = cc_q + 1'b1;
            end
`else
            done_d = last_px;
`endif
        end
    end

    // State, counters, window registers and output strobes.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= STREAM;
            col_q   <= '0;
            row_q   <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            for (int i = 0; i < K; i++) begin
                for (int j = 0; j < K; j++) begin
                    win_q[i][j] <= '0;
                    out_q[i][j] <= '0;
                end
            end
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            row_q   <= row_d;
            valid_q <= valid_d;
            done_q  <= done_d;
            win_q   <= win_d;
            out_q   <= out_d;
        end
    end

`ifdef SOBEL_WINDOW_ZERO_PAD_EN
    // Flush counter and window-centre position.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            fcnt_q <= '0;
            cr_q   <= '0;
            cc_q   <= '0;
        end else begin
            fcnt_q <= fcnt_d;
            cr_q   <= cr_d;
            cc_q   <= cc_d;
        end
    end
`endif

    // Line buffers: older line moves up, incoming pixel enters the newer line.
    always_ff @(posedge i_clk) begin
        if (adv) begin
            lb0_q[addr] <= lb1_q[addr];
            lb1_q[addr] <= pix;
        end
    end

endmodule
